// File: rtl/sa_writeback_cache_pkg.sv
// Shared definitions for the 2-way set-associative write-back cache.
//   state_t      : controller state encoding (also useful to checkers binding to the FSM)
//   tag_width()  : derives the tag width from the address and index widths
//   line_*()     : bit offsets of the fields of one cache line {valid, dirty, tag, data}
package sa_writeback_cache_pkg;

  localparam int NUM_WAYS = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_WB      = 3'd2,
    ST_FILL    = 3'd3,
    ST_RESP    = 3'd4,
    ST_FL_SCAN = 3'd5,
    ST_FL_WB   = 3'd6,
    ST_FL_DONE = 3'd7
  } state_t;

  function automatic int tag_width(input int addr_w, input int set_bits);
    return addr_w - set_bits;
  endfunction

  // Line layout, LSB first: data, tag, dirty, valid.
  function automatic int line_tag_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int line_dirty_bit(input int data_w, input int tag_w);
    return data_w + tag_w;
  endfunction

  function automatic int line_valid_bit(input int data_w, input int tag_w);
    return data_w + tag_w + 1;
  endfunction

endpackage

// File: rtl/sa_writeback_cache_tag_array.sv
// cache_tag_array: storage for both ways of every set plus one LRU bit per set.
//   clk, rst             : clock, async active-high reset (clears valid, dirty and LRU)
//   rd_set               : read index; rd_* outputs show both ways of that set combinationally
//   rd_valid/dirty/tag/data, rd_lru : contents of set rd_set
//   wr_en, wr_set, wr_way, wr_valid, wr_dirty, wr_tag, wr_data : single line write port
//   lru_we, lru_set, lru_val : LRU bit write port
//   clr_all              : invalidate every line and zero every LRU bit (takes priority)
module cache_tag_array
  import sa_writeback_cache_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TAG_W    = 5,
  parameter int SET_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SET_BITS-1:0]            rd_set,
  output logic [NUM_WAYS-1:0]            rd_valid,
  output logic [NUM_WAYS-1:0]            rd_dirty,
  output logic [NUM_WAYS-1:0][TAG_W-1:0] rd_tag,
  output logic [NUM_WAYS-1:0][DATA_W-1:0] rd_data,
  output logic                           rd_lru,
  input  logic                           wr_en,
  input  logic [SET_BITS-1:0]            wr_set,
  input  logic                           wr_way,
  input  logic                           wr_valid,
  input  logic                           wr_dirty,
  input  logic [TAG_W-1:0]               wr_tag,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           lru_we,
  input  logic [SET_BITS-1:0]            lru_set,
  input  logic                           lru_val,
  input  logic                           clr_all
);

  localparam int SETS = 1 << SET_BITS;

  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [NUM_WAYS-1:0] dirty_q [SETS];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [NUM_WAYS][SETS];
  logic [DATA_W-1:0]   data_q  [NUM_WAYS][SETS];

  // Control bits: reset and flush-clear apply here only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      lru_q <= '0;
    end else if (clr_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_set][wr_way] <= wr_valid;
        dirty_q[wr_set][wr_way] <= wr_dirty;
      end
      if (lru_we) begin
        lru_q[lru_set] <= lru_val;
      end
    end
  end

  // Payload needs no reset: it is never used while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][wr_set]  <= wr_tag;
      data_q[wr_way][wr_set] <= wr_data;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_valid[w] = valid_q[rd_set][w];
      rd_dirty[w] = dirty_q[rd_set][w];
      rd_tag[w]   = tag_q[w][rd_set];
      rd_data[w]  = data_q[w][rd_set];
    end
    rd_lru = lru_q[rd_set];
  end

endmodule

// File: rtl/sa_writeback_cache.sv
// sa_writeback_cache: 2-way set-associative write-back cache, one word per line.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : processor request, sampled only in IDLE
//   cpu_rdata/cpu_ready               : completion; cpu_ready is a one-cycle pulse
//   flush/flush_done                  : write back all dirty lines, then invalidate everything
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : RAM port
// Handshakes: a requester raises cpu_req (or flush) and holds it and its payload until it sees
// cpu_ready (flush_done); the cache samples it only in IDLE. Toward RAM the cache raises mem_req
// with a stable mem_we/mem_addr/mem_wdata and holds it until a cycle with mem_ack=1 completes the
// transfer; mem_req drops on the following cycle and mem_ack without mem_req is ignored.
module sa_writeback_cache
  import sa_writeback_cache_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int SET_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W = tag_width(ADDR_W, SET_BITS);
  localparam logic [SET_BITS:0] SCAN_ONE  = {{SET_BITS{1'b0}}, 1'b1};
  localparam logic [SET_BITS:0] SCAN_LAST = {(SET_BITS+1){1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                way_q;
  // Flush cursor {set, way}: way in the LSB so both ways of a set are visited back to back.
  logic [SET_BITS:0]   scan_q;

  logic [TAG_W-1:0]    req_tag;
  logic [SET_BITS-1:0] req_set;
  logic [SET_BITS-1:0] scan_set;
  logic                scan_way;
  logic [SET_BITS-1:0] rd_set;

  logic [NUM_WAYS-1:0]             rd_valid;
  logic [NUM_WAYS-1:0]             rd_dirty;
  logic [NUM_WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [NUM_WAYS-1:0][DATA_W-1:0] rd_data;
  logic                            rd_lru;

  logic                wr_en, wr_way, wr_valid, wr_dirty;
  logic [SET_BITS-1:0] wr_set;
  logic [TAG_W-1:0]    wr_tag;
  logic [DATA_W-1:0]   wr_data;
  logic                lru_we, lru_val, clr_all;
  logic [SET_BITS-1:0] lru_set;

  logic hit0, hit1, hit, hit_way, victim, ack_ok;

  assign req_tag  = addr_q[ADDR_W-1:SET_BITS];
  assign req_set  = addr_q[SET_BITS-1:0];
  assign scan_set = scan_q[SET_BITS:1];
  assign scan_way = scan_q[0];
  assign rd_set   = (state == ST_FL_SCAN || state == ST_FL_WB) ? scan_set : req_set;

  assign hit0    = rd_valid[0] && (rd_tag[0] == req_tag);
  assign hit1    = rd_valid[1] && (rd_tag[1] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  // Fill an empty way before evicting anything; otherwise evict the way LRU points at.
  assign victim  = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);
  assign ack_ok  = mem_req && mem_ack;

  cache_tag_array #(
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W),
    .SET_BITS (SET_BITS)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .rd_set   (rd_set),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_lru   (rd_lru),
    .wr_en    (wr_en),
    .wr_set   (wr_set),
    .wr_way   (wr_way),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .lru_we   (lru_we),
    .lru_set  (lru_set),
    .lru_val  (lru_val),
    .clr_all  (clr_all)
  );

  // Tag-array update strobes, decoded from the current state and RAM completion.
  always_comb begin
    wr_en    = 1'b0;
    wr_set   = req_set;
    wr_way   = way_q;
    wr_valid = 1'b1;
    wr_dirty = 1'b0;
    wr_tag   = req_tag;
    wr_data  = wdata_q;
    lru_we   = 1'b0;
    lru_set  = req_set;
    lru_val  = 1'b0;
    clr_all  = 1'b0;
    case (state)
      ST_LOOKUP: begin
        if (hit) begin
          lru_we  = 1'b1;
          lru_val = !hit_way;
          if (we_q) begin
            wr_en    = 1'b1;
            wr_way   = hit_way;
            wr_dirty = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (ack_ok) begin
          wr_en    = 1'b1;
          wr_dirty = we_q;
          wr_data  = we_q ? wdata_q : mem_rdata;
          lru_we   = 1'b1;
          lru_val  = !way_q;
        end
      end
      ST_FL_WB: begin
        // Written back: rewrite the same line with dirty cleared.
        if (ack_ok) begin
          wr_en   = 1'b1;
          wr_set  = scan_set;
          wr_way  = scan_way;
          wr_tag  = rd_tag[scan_way];
          wr_data = rd_data[scan_way];
        end
      end
      ST_FL_DONE: clr_all = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      way_q      <= 1'b0;
      scan_q     <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            scan_q <= '0;
            state  <= ST_FL_SCAN;
          end else if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            cpu_rdata <= we_q ? wdata_q : rd_data[hit_way];
            cpu_ready <= 1'b1;
            state     <= ST_RESP;
          end else begin
            way_q   <= victim;
            mem_req <= 1'b1;
            if (rd_valid[victim] && rd_dirty[victim]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {rd_tag[victim], req_set};
              mem_wdata <= rd_data[victim];
              state     <= ST_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= addr_q;
              state    <= ST_FILL;
            end
          end
        end
        ST_WB: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Arriving from WB, mem_req is low for one cycle before the fill is issued.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_q;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= we_q ? wdata_q : mem_rdata;
            cpu_ready <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_FL_SCAN: begin
          if (rd_valid[scan_way] && rd_dirty[scan_way]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {rd_tag[scan_way], scan_set};
            mem_wdata <= rd_data[scan_way];
            state     <= ST_FL_WB;
          end else if (scan_q == SCAN_LAST) begin
            flush_done <= 1'b1;
            state      <= ST_FL_DONE;
          end else begin
            scan_q <= scan_q + SCAN_ONE;
          end
        end
        ST_FL_WB: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (scan_q == SCAN_LAST) begin
              flush_done <= 1'b1;
              state      <= ST_FL_DONE;
            end else begin
              scan_q <= scan_q + SCAN_ONE;
              state  <= ST_FL_SCAN;
            end
          end
        end
        ST_FL_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_writeback_cache.sv
// Directed bench for sa_writeback_cache (DATA_W=8, ADDR_W=8, SET_BITS=3).
// RAM model: ram[a] = a + 0x80 initially; acks after ack_lat cycles of mem_req and logs every
// completed transfer as {we, addr, data}. Expected transfers go into exp_q and are compared in order.
module tb_sa_writeback_cache;

  logic       clk, rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_ready, flush, flush_done;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ram [256];
  int          ack_lat = 3;
  int          ack_cnt;
  logic [16:0] mem_log [$];
  logic [16:0] exp_q   [$];
  int          ready_cnt = 0;

  sa_writeback_cache #(.DATA_W(8), .ADDR_W(8), .SET_BITS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (cpu_ready) ready_cnt <= ready_cnt + 1;

  // ---------------- RAM model ----------------
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    ack_cnt = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 8'h80);
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (mem_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            mem_log.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = ram[mem_addr];
            mem_log.push_back({1'b0, mem_addr, ram[mem_addr]});
          end
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_mem(input logic we, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back({we, addr, data});
  endtask

  // Compares the RAM transfer log against exp_q in order, then empties both.
  task automatic check_mem(input string tag);
    int n;
    check({tag, "_count"}, mem_log.size(), exp_q.size());
    n = (mem_log.size() < exp_q.size()) ? mem_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_xfer%0d", tag, i), mem_log[i], exp_q[i]);
    mem_log.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"},  cpu_ready,  0);
    check({tag, "_rdata"},  cpu_rdata,  0);
    check({tag, "_fdone"},  flush_done, 0);
    check({tag, "_mreq"},   mem_req,    0);
    check({tag, "_mwe"},    mem_we,     0);
    check({tag, "_maddr"},  mem_addr,   0);
    check({tag, "_mwdata"}, mem_wdata,  0);
  endtask

  // ---------------- drivers ----------------
  // lat = clock edges from the sampling edge up to the edge that captures cpu_ready.
  task automatic cpu_op(input string tag, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    bit seen = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cpu_ready) seen = 1;
    end
    cpu_req = 1'b0;
    rdata = cpu_rdata;
    if (!seen) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    check({tag, "_ready_pulse"}, cpu_ready, 0);
  endtask

  task automatic flush_op(input string tag, input logic with_req, input logic [7:0] addr,
                          output int cycles);
    bit seen = 0;
    @(negedge clk);
    flush = 1'b1;
    if (with_req) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = '0;
    end
    cycles = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (flush_done) seen = 1;
    end
    flush = 1'b0;
    cpu_req = 1'b0;
    if (!seen) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, flush_done, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rd;
  int         lat, cyc, rc0;

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; flush = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_released");

    // 1: cold read miss -> one fill
    cpu_op("t1_read25", 0, 8'h25, 8'h00, rd, lat);
    check("t1_rdata", rd, 8'hA5);
    expect_mem(0, 8'h25, 8'hA5);
    check_mem("t1_mem");

    // 2: repeat read hits with the minimum latency
    cpu_op("t2_read25", 0, 8'h25, 8'h00, rd, lat);
    check("t2_rdata", rd, 8'hA5);
    check("t2_latency", lat, 2);
    check_mem("t2_mem");

    // 3: fill set 5 with two writes, then a read evicts the dirty LRU line 0x05
    cpu_op("t3_wr05", 1, 8'h05, 8'h11, rd, lat);
    cpu_op("t3_wr15", 1, 8'h15, 8'h22, rd, lat);
    expect_mem(0, 8'h05, 8'h85);
    expect_mem(0, 8'h15, 8'h95);
    check_mem("t3_wr_mem");
    cpu_op("t3_read25", 0, 8'h25, 8'h00, rd, lat);
    check("t3_rdata25", rd, 8'hA5);
    expect_mem(1, 8'h05, 8'h11);
    expect_mem(0, 8'h25, 8'hA5);
    check_mem("t3_evict_mem");
    check("t3_ram05", ram[8'h05], 8'h11);
    cpu_op("t3_read15", 0, 8'h15, 8'h00, rd, lat);
    check("t3_rdata15", rd, 8'h22);
    check("t3_latency15", lat, 2);
    check_mem("t3_hit_mem");

    // 4: flush out the dirty 0x15, time a clean flush, then flush sets 0 and 7
    flush_op("t4_flush_a", 0, 8'h00, cyc);
    expect_mem(1, 8'h15, 8'h22);
    check_mem("t4_flush_a_mem");
    flush_op("t4_flush_clean", 0, 8'h00, cyc);
    check("t4_clean_cycles", cyc, 17);
    check_mem("t4_clean_mem");
    cpu_op("t4_wr38", 1, 8'h38, 8'h33, rd, lat);
    cpu_op("t4_wr07", 1, 8'h07, 8'h44, rd, lat);
    expect_mem(0, 8'h38, 8'hB8);
    expect_mem(0, 8'h07, 8'h87);
    check_mem("t4_wr_mem");
    flush_op("t4_flush_b", 0, 8'h00, cyc);
    expect_mem(1, 8'h38, 8'h33);
    expect_mem(1, 8'h07, 8'h44);
    check_mem("t4_flush_b_mem");
    cpu_op("t4_read38", 0, 8'h38, 8'h00, rd, lat);
    check("t4_rdata38", rd, 8'h33);
    cpu_op("t4_read07", 0, 8'h07, 8'h00, rd, lat);
    check("t4_rdata07", rd, 8'h44);
    expect_mem(0, 8'h38, 8'h33);
    expect_mem(0, 8'h07, 8'h44);
    check_mem("t4_miss_mem");

    // 5: reset while a write-back is outstanding
    cpu_op("t5_wr40", 1, 8'h40, 8'h55, rd, lat);
    cpu_op("t5_wr48", 1, 8'h48, 8'h66, rd, lat);
    expect_mem(0, 8'h40, 8'hC0);
    expect_mem(0, 8'h48, 8'hC8);
    check_mem("t5_setup_mem");
    ack_lat = 50;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h77;
    begin
      bit up = 0;
      for (int i = 0; i < 20 && !up; i++) begin
        @(negedge clk);
        if (mem_req) up = 1;
      end
      check("t5_wb_started", up, 1);
    end
    check("t5_wb_we", mem_we, 1);
    check("t5_wb_addr", mem_addr, 8'h40);
    check("t5_wb_data", mem_wdata, 8'h55);
    #3 rst = 1'b1;
    #1 check_outputs_zero("t5_async_rst");
    @(negedge clk);
    cpu_req = 1'b0;
    ack_lat = 3;
    @(negedge clk);
    rst = 1'b0;
    check_mem("t5_abort_mem");
    check("t5_ram40", ram[8'h40], 8'hC0);
    cpu_op("t5_read48", 0, 8'h48, 8'h00, rd, lat);
    check("t5_rdata48", rd, 8'hC8);
    expect_mem(0, 8'h48, 8'hC8);
    check_mem("t5_empty_mem");

    // 6: flush and request together; the flush wins and the request is dropped
    cpu_op("t6_wr01", 1, 8'h01, 8'h99, rd, lat);
    expect_mem(0, 8'h01, 8'h81);
    check_mem("t6_setup_mem");
    rc0 = ready_cnt;
    flush_op("t6_flush", 1, 8'h02, cyc);
    repeat (5) @(negedge clk);
    check("t6_no_ready", ready_cnt - rc0, 0);
    expect_mem(1, 8'h01, 8'h99);
    check_mem("t6_flush_mem");
    cpu_op("t6_read02", 0, 8'h02, 8'h00, rd, lat);
    check("t6_rdata02", rd, 8'h82);
    expect_mem(0, 8'h02, 8'h82);
    check_mem("t6_reissue_mem");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
